// File: rtl/axis_gatekeeper_sched_pkg.sv
// axis_gatekeeper_sched_pkg: shared types and helpers for the token-bucket
// gatekeeper scheduler (state enum, allow-count width, round-robin index step).
package axis_gatekeeper_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sched_state_t;

   localparam int ALLOW_COUNT_W = 9;

   // Next index in round-robin order, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/axis_gatekeeper_sched_rr.sv
// rr_arbiter: combinational round-robin select over N request bits.
// Ports: last (previous grant index), req (requests) -> valid, index.
module rr_arbiter
   import axis_gatekeeper_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [IW-1:0] last,
   input  logic [N-1:0]  req,
   output logic          valid,
   output logic [IW-1:0] index
);

   int          cand;
   logic [IW-1:0] cand_idx;

   // Scan starting one past the last grant; first hit wins.
   always_comb begin
      valid    = 1'b0;
      index    = last;
      cand     = rr_next(int'(last), N);
      cand_idx = IW'(cand);
      for (int i = 0; i < N; i++) begin
         cand_idx = IW'(cand);
         if (!valid && req[cand_idx]) begin
            valid = 1'b1;
            index = cand_idx;
         end
         cand = rr_next(cand, N);
      end
   end

endmodule

// File: rtl/axis_gatekeeper_sched.sv
// axis_gatekeeper_sched: token-bucket scheduler granting s_allow pulses
// round-robin to up to NUM_CH AXI4-Stream gatekeepers.
// Ports:
//   aclk, aresetn       clock, synchronous active-low reset
//   enable              global run (low forces IDLE)
//   period              token period minus 1
//   ch_enable           per-channel grant enable
//   max_credit          per-channel outstanding-credit ceiling
//   allow_count         concatenated s_allow_count, 9 bits per channel
//   allow               one-cycle grant pulses (one-hot or zero)
//   grant_ch            index of the last grant
//   bucket              current token count
//   overflow_count      saturating count of dropped tokens
//   running             high in RUN
module axis_gatekeeper_sched
   import axis_gatekeeper_sched_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int PERIOD_WIDTH = 16,
   parameter int BUCKET_MAX   = 8,
   localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic                            enable,
   input  logic [PERIOD_WIDTH-1:0]         period,
   input  logic [NUM_CH-1:0]               ch_enable,
   input  logic [ALLOW_COUNT_W-1:0]        max_credit,
   input  logic [NUM_CH*ALLOW_COUNT_W-1:0] allow_count,
   output logic [NUM_CH-1:0]               allow,
   output logic [GW-1:0]                   grant_ch,
   output logic [3:0]                      bucket,
   output logic [15:0]                     overflow_count,
   output logic                            running
);

   localparam logic [3:0] BMAX = 4'(BUCKET_MAX);

   sched_state_t              state_q;
   sched_state_t              state_d;
   logic [PERIOD_WIDTH-1:0]   pcnt_q;
   logic                      run_act;
   logic                      tick;
   logic                      grant;
   logic [NUM_CH-1:0]         elig;
   logic [NUM_CH-1:0]         req;
   logic [ALLOW_COUNT_W:0]    eff [NUM_CH];
   logic                      arb_valid;
   logic [GW-1:0]             arb_idx;

   // A RUN cycle with enable low is the exit cycle: no tick, no grant.
   assign run_act = (state_q == RUN) && enable;
   assign tick    = run_act && (pcnt_q == '0);
   assign running = (state_q == RUN);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable)  state_d = RUN;
         RUN:     if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outside active RUN the counter keeps reloading, so the first
   // tick lands period+1 cycles after entering RUN.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         pcnt_q <= '0;
      end else if (!run_act || pcnt_q == '0) begin
         pcnt_q <= period;
      end else begin
         pcnt_q <= pcnt_q - 1'b1;
      end
   end

   // Count the pulse still in flight: the gatekeeper has not yet
   // registered allow[i] in its own count.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         eff[i]  = (ALLOW_COUNT_W+1)'(allow_count[i*ALLOW_COUNT_W +: ALLOW_COUNT_W])
                 + (ALLOW_COUNT_W+1)'(allow[i]);
         elig[i] = ch_enable[i] && (eff[i] < {1'b0, max_credit});
      end
   end

   assign req = elig & {NUM_CH{run_act && (bucket != 4'd0)}};

   rr_arbiter #(
      .N  (NUM_CH),
      .IW (GW)
   ) u_arb (
      .last  (grant_ch),
      .req   (req),
      .valid (arb_valid),
      .index (arb_idx)
   );

   assign grant = arb_valid;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         bucket <= 4'd0;
      end else if (!run_act) begin
         bucket <= 4'd0;
      end else begin
         unique case (1'b1)
            (tick && !grant && bucket != BMAX): bucket <= bucket + 4'd1;
            (grant && !tick):                   bucket <= bucket - 4'd1;
            default:                            bucket <= bucket;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         overflow_count <= 16'd0;
      end else if (tick && !grant && bucket == BMAX
                   && overflow_count != 16'hFFFF) begin
         overflow_count <= overflow_count + 16'd1;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         allow    <= '0;
         grant_ch <= GW'(NUM_CH - 1);
      end else begin
         allow <= grant ? (NUM_CH'(1) << arb_idx) : '0;
         if (grant) begin
            grant_ch <= arb_idx;
         end
      end
   end

endmodule

// File: tb/tb_axis_gatekeeper_sched.sv
// tb_axis_gatekeeper_sched: scoreboard bench for axis_gatekeeper_sched with
// a no-traffic gatekeeper count model on allow_count.
module tb_axis_gatekeeper_sched;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        enable;
   logic [15:0] period;
   logic [3:0]  ch_enable;
   logic [8:0]  max_credit;
   logic [35:0] allow_count;
   logic [3:0]  allow;
   logic [1:0]  grant_ch;
   logic [3:0]  bucket;
   logic [15:0] overflow_count;
   logic        running;

   logic [8:0]  cnt [4];
   logic        cnt_clr;
   int          sb [$];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 aclk = ~aclk;

   axis_gatekeeper_sched #(
      .NUM_CH       (4),
      .PERIOD_WIDTH (16),
      .BUCKET_MAX   (8)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .enable         (enable),
      .period         (period),
      .ch_enable      (ch_enable),
      .max_credit     (max_credit),
      .allow_count    (allow_count),
      .allow          (allow),
      .grant_ch       (grant_ch),
      .bucket         (bucket),
      .overflow_count (overflow_count),
      .running        (running)
   );

   // Gatekeeper with no downstream traffic: each pulse adds one credit.
   always @(posedge aclk) begin
      for (int i = 0; i < 4; i++) begin
         if (cnt_clr) cnt[i] <= '0;
         else         cnt[i] <= cnt[i] + 9'(allow[i]);
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) allow_count[i*9 +: 9] = cnt[i];
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge aclk) begin
      if (allow != 4'd0) begin
         if (sb.size() == 0) begin
            check("extra_allow", 32'(allow), 0);
         end else begin
            int e;
            e = sb.pop_front();
            check("allow_ch", 32'(allow), 32'(1) << e);
         end
      end
   end

   task automatic wait_allow(input int maxc, output int n);
      n = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge aclk);
         n++;
         if (allow != 4'd0) break;
      end
   endtask

   task automatic wait_bucket(input logic [3:0] v, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         @(negedge aclk);
         if (bucket == v) break;
      end
   endtask

   task automatic count_allows(input int target, input int maxc,
                               output int seen);
      seen = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge aclk);
         if (allow != 4'd0) seen++;
         if (seen == target) break;
      end
   endtask

   initial begin
      int n;
      int seen;
      logic [15:0] ov0;

      // reset state
      aresetn = 1'b0; enable = 1'b0; period = 16'd3;
      ch_enable = 4'hF; max_credit = 9'd100; cnt_clr = 1'b1;
      repeat (3) @(negedge aclk);
      check("rst_allow", 32'(allow), 0);
      check("rst_grant_ch", 32'(grant_ch), 3);
      check("rst_bucket", 32'(bucket), 0);
      check("rst_overflow", 32'(overflow_count), 0);
      check("rst_running", 32'(running), 0);

      // period 3, all channels: 0,1,2,3,0 every 4 cycles
      aresetn = 1'b1; cnt_clr = 1'b0;
      sb.push_back(0); sb.push_back(1); sb.push_back(2);
      sb.push_back(3); sb.push_back(0);
      enable = 1'b1;
      @(negedge aclk);
      check("t1_running", 32'(running), 1);
      wait_allow(20, n);
      check("t1_first_latency", n, 5);
      for (int k = 1; k < 5; k++) begin
         wait_allow(20, n);
         check("t1_gap", n, 4);
      end
      enable = 1'b0;

      // period 0, ch1 only, max_credit 2
      @(negedge aclk);
      period = 16'd0; ch_enable = 4'b0010; max_credit = 9'd2; cnt_clr = 1'b1;
      @(negedge aclk);
      cnt_clr = 1'b0;
      sb.push_back(1); sb.push_back(1);
      enable = 1'b1;
      wait_bucket(4'd8, 40);
      check("t2_bucket_full", 32'(bucket), 8);
      check("t2_pulses_seen", sb.size(), 0);

      // overflow once per tick; tick+grant keeps bucket at 8
      ov0 = overflow_count;
      repeat (3) @(negedge aclk);
      check("t3_overflow_rate", 32'(overflow_count), 32'(ov0) + 3);
      check("t3_bucket_hold", 32'(bucket), 8);
      sb.push_back(1);
      max_credit = 9'd3;
      ov0 = overflow_count;
      @(negedge aclk);
      check("t3_grant_pulse", 32'(allow), 32'b0010);
      check("t3_bucket_tick_grant", 32'(bucket), 8);
      check("t3_no_overflow", 32'(overflow_count), 32'(ov0));
      @(negedge aclk);
      check("t3_overflow_resume", 32'(overflow_count), 32'(ov0) + 1);

      // setup grant_ch=2, then alternate 0/2
      enable = 1'b0;
      @(negedge aclk);
      ch_enable = 4'b0100; max_credit = 9'd1; cnt_clr = 1'b1;
      sb.push_back(2);
      @(negedge aclk);
      cnt_clr = 1'b0; enable = 1'b1;
      wait_allow(20, n);
      @(negedge aclk);
      check("t4_grant_ch", 32'(grant_ch), 2);
      check("t4_no_regrant", 32'(allow), 0);
      ch_enable = 4'b0101; max_credit = 9'd100;
      for (int k = 0; k < 3; k++) begin
         sb.push_back(0); sb.push_back(2);
      end
      count_allows(6, 30, seen);
      enable = 1'b0;
      check("t4_alternations", seen, 6);

      // drop enable at bucket 5, re-enable with period 3
      @(negedge aclk);
      ch_enable = 4'b0000; enable = 1'b1;
      wait_bucket(4'd5, 20);
      check("t5_bucket5", 32'(bucket), 5);
      enable = 1'b0; period = 16'd3;
      @(negedge aclk);
      check("t5_running_off", 32'(running), 0);
      check("t5_bucket_clr", 32'(bucket), 0);
      check("t5_allow_off", 32'(allow), 0);
      enable = 1'b1;
      @(negedge aclk);
      check("t5_running_on", 32'(running), 1);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         n++;
         if (bucket != 4'd0) break;
      end
      check("t5_first_tick", n, 4);

      // reset during an active pulse
      enable = 1'b0;
      @(negedge aclk);
      ch_enable = 4'hF; max_credit = 9'd100; period = 16'd0; cnt_clr = 1'b1;
      sb.push_back(3); sb.push_back(0);
      @(negedge aclk);
      cnt_clr = 1'b0; enable = 1'b1;
      count_allows(2, 20, seen);
      check("t6_pulses", seen, 2);
      check("t6_overflow_nonzero", 32'(overflow_count != 16'd0), 1);
      aresetn = 1'b0; enable = 1'b0;
      @(negedge aclk);
      check("t6_allow", 32'(allow), 0);
      check("t6_overflow", 32'(overflow_count), 0);
      check("t6_grant_ch", 32'(grant_ch), 3);
      check("t6_bucket", 32'(bucket), 0);
      check("t6_running", 32'(running), 0);
      aresetn = 1'b1;
      repeat (3) @(negedge aclk);
      check("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
